// File: rtl/washing_pkg.sv
// rtl/washing_pkg.sv - shared types and defaults for the laundry inlet arbiter
package washing_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_SETTLE = 2'd2
  } arb_state_t;

  localparam int DEF_MAX_FILL = 64;
  localparam int DEF_SETTLE   = 2;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first set req bit at or after ptr
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [N-1:0] rotated;
  logic [IW-1:0] enc;
  logic [IW:0]   sum;
  logic          hit;

  always_comb begin
    rotated = '0;
    for (int i = 0; i < N; i++) begin
      rotated[i] = req[(i + int'(ptr)) % N];
    end

    enc = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit && rotated[i]) begin
        enc = IW'(i);
        hit = 1'b1;
      end
    end

    // Undo the rotation: encoded offset is relative to ptr.
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end

    index = sum[IW-1:0];
    valid = hit;
    pick  = hit ? (N'(1) << index) : '0;
  end

endmodule

// File: rtl/water_supply_arbiter.sv
// rtl/water_supply_arbiter.sv - round-robin sharing of one mains inlet among N washing machines
module water_supply_arbiter #(
  parameter int N_MACH   = 4,
  parameter int MAX_FILL = washing_pkg::DEF_MAX_FILL,
  parameter int SETTLE   = washing_pkg::DEF_SETTLE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_MACH-1:0]         fill_req,
  input  logic [N_MACH-1:0]         level_full,
  input  logic [N_MACH-1:0]         fault_clr,
  output logic [N_MACH-1:0]         grant,
  output logic [$clog2(N_MACH)-1:0] grant_id,
  output logic                      supply_valve_on,
  output logic [N_MACH-1:0]         fault,
  output logic                      busy
);
  import washing_pkg::*;

  localparam int IW = $clog2(N_MACH);
  localparam int TW = $clog2(MAX_FILL);
  localparam int SW = $clog2(SETTLE + 1);

  arb_state_t        state;
  logic [IW-1:0]     rr_ptr;
  logic [TW-1:0]     timer;
  logic [SW-1:0]     settle_cnt;

  logic [N_MACH-1:0] elig;
  logic [N_MACH-1:0] pick;
  logic [IW-1:0]     pick_id;
  logic              pick_valid;

  logic              at_full;
  logic              withdrawn;
  logic              timed_out;
  logic              grant_end;
  logic [N_MACH-1:0] fault_set;

  assign elig = fill_req & ~level_full & ~fault;

  rr_priority_pick #(
    .N  (N_MACH),
    .IW (IW)
  ) u_pick (
    .req   (elig),
    .ptr   (rr_ptr),
    .pick  (pick),
    .index (pick_id),
    .valid (pick_valid)
  );

  // Exit causes in priority order; only a pure timeout raises a fault.
  always_comb begin
    at_full   = level_full[grant_id];
    withdrawn = !fill_req[grant_id];
    timed_out = (timer == TW'(MAX_FILL - 1));
    grant_end = (state == ARB_GRANT) && (at_full || withdrawn || timed_out);
    fault_set = '0;
    if ((state == ARB_GRANT) && !at_full && !withdrawn && timed_out) begin
      fault_set = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      timer      <= '0;
      settle_cnt <= '0;
      fault      <= '0;
    end else begin
      // A set in the same cycle as a clear wins.
      fault <= (fault & ~fault_clr) | fault_set;

      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant    <= pick;
            grant_id <= pick_id;
            timer    <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (grant_end) begin
            grant      <= '0;
            grant_id   <= '0;
            rr_ptr     <= (grant_id == IW'(N_MACH - 1)) ? '0 : grant_id + IW'(1);
            settle_cnt <= '0;
            state      <= ARB_SETTLE;
          end else if (timer != TW'(MAX_FILL - 1)) begin
            timer <= timer + TW'(1);
          end
        end
        ARB_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            state <= ARB_IDLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign supply_valve_on = |grant;
  assign busy            = (state != ARB_IDLE);

endmodule

// File: tb/tb_water_supply_arbiter.sv
// tb/tb_water_supply_arbiter.sv - self-checking bench for water_supply_arbiter
module tb_water_supply_arbiter;

  localparam int N  = 4;
  localparam int MF = 8;
  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] fill_req = '0;
  logic [3:0] level_full = '0;
  logic [3:0] fault_clr = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       supply_valve_on;
  logic [3:0] fault;
  logic       busy;

  water_supply_arbiter #(
    .N_MACH   (N),
    .MAX_FILL (MF),
    .SETTLE   (ST)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fill_req        (fill_req),
    .level_full      (level_full),
    .fault_clr       (fault_clr),
    .grant           (grant),
    .grant_id        (grant_id),
    .supply_valve_on (supply_valve_on),
    .fault           (fault),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the inlet, how long, and how many quiet cycles remain.
  int         m_owner;
  int         m_elapsed;
  int         m_quiet;
  int         m_ptr;
  logic [3:0] m_fault;

  typedef struct {
    logic [3:0] fr;
    logic [3:0] lf;
    logic [3:0] fc;
    logic [3:0] g;
    logic [3:0] f;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner   = -1;
    m_elapsed = 0;
    m_quiet   = 0;
    m_ptr     = 0;
    m_fault   = '0;
  endfunction

  function automatic void model_step(input logic [3:0] fr, input logic [3:0] lf, input logic [3:0] fc);
    logic [3:0] setm = '0;
    logic [3:0] elig;
    if (m_owner >= 0) begin
      if (lf[m_owner] || !fr[m_owner] || m_elapsed == MF) begin
        if (!lf[m_owner] && fr[m_owner]) setm[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_quiet = ST;
      end else begin
        m_elapsed++;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      elig = fr & ~lf & ~m_fault;
      for (int k = 0; k < N; k++) begin
        int m;
        m = (m_ptr + k) % N;
        if (elig[m]) begin
          m_owner   = m;
          m_elapsed = 1;
          break;
        end
      end
    end
    m_fault = (m_fault & ~fc) | setm;
  endfunction

  task automatic compare_model();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    check("grant", grant, eg);
    check("grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
    check("supply_valve_on", supply_valve_on, m_owner >= 0);
    check("fault", fault, m_fault);
    check("busy", busy, (m_owner >= 0) || (m_quiet > 0));
  endtask

  task automatic cycle(input logic [3:0] fr, input logic [3:0] lf, input logic [3:0] fc);
    fill_req   = fr;
    level_full = lf;
    fault_clr  = fc;
    model_step(fr, lf, fc);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fill_req = '0;
    level_full = '0;
    fault_clr = '0;
    model_reset();
    #1;
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_supply", supply_valve_on, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void add(input logic [3:0] fr, input logic [3:0] lf, input logic [3:0] fc,
                              input logic [3:0] g, input logic [3:0] f, input logic b);
    vec_t v;
    v.fr = fr; v.lf = lf; v.fc = fc; v.g = g; v.f = f; v.b = b;
    tbl.push_back(v);
  endfunction

  initial begin
    int         order[$];
    int         zero_run;
    int         onsets;
    logic [3:0] prev_g;
    logic [3:0] fr;
    logic [3:0] lf;
    logic [3:0] fc;
    logic       m3_seen;
    int         exp_order[5] = '{0, 1, 2, 3, 0};

    do_reset();

    // Single request then timeout on machine 2 with coincident clear.
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1);
    add(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1);
    add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    add(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    foreach (tbl[i]) begin
      cycle(tbl[i].fr, tbl[i].lf, tbl[i].fc);
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      check($sformatf("tbl%0d_fault", i), fault, tbl[i].f);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
    end

    // Round-robin: all request, each fills for 2 cycles.
    do_reset();
    prev_g   = '0;
    zero_run = 0;
    onsets   = 0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      lf = (m_owner >= 0 && m_elapsed == 2) ? 4'(1 << m_owner) : 4'd0;
      cycle(4'b1111, lf, 4'b0000);
      check("rr_onehot", $countones(grant) <= 1, 1);
      if (grant != 0 && prev_g == 0) begin
        if (onsets > 0) check("rr_gap", zero_run >= ST + 1, 1);
        order.push_back(int'(grant_id));
        onsets++;
        zero_run = 0;
      end else if (grant == 0) begin
        zero_run++;
      end
      prev_g = grant;
    end
    check("rr_count", order.size(), 5);
    foreach (order[k]) if (k < 5) check($sformatf("rr_order%0d", k), order[k], exp_order[k]);

    // Withdrawal of machine 1; machine 3 is full and must be skipped.
    do_reset();
    m3_seen = 1'b0;
    cycle(4'b1010, 4'b1000, 4'b0000);
    check("wd_grant1", grant, 4'b0010);
    cycle(4'b1010, 4'b1000, 4'b0000);
    cycle(4'b1000, 4'b1000, 4'b0000);
    check("wd_release", grant, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b1011, 4'b1000, 4'b0000);
      m3_seen |= grant[3];
    end
    check("wd_ptr_pick0", grant, 4'b0001);
    check("wd_skip3", m3_seen, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    fr = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(9) == 0) fr[b] = ~fr[b];
        lf[b] = ($urandom_range(99) < 12);
        fc[b] = ($urandom_range(99) < 4);
      end
      cycle(fr, lf, fc);
    end

    // Reset asserted while machine 1 holds the inlet.
    cycle(4'b0000, 4'b0000, 4'b1111);
    for (int c = 0; c < 10 && (m_owner >= 0 || m_quiet > 0); c++) cycle(4'b0000, 4'b0000, 4'b0000);
    for (int c = 0; c < 20 && m_owner != 1; c++) cycle(4'b0010, 4'b0000, 4'b0000);
    check("mid_pre_grant", grant, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_supply", supply_valve_on, 1'b0);
    check("mid_rst_fault", fault, 4'b0000);
    check("mid_rst_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b1000, 4'b0000, 4'b0000);
    check("post_rst_grant", grant, 4'b1000);
    check("post_rst_id", grant_id, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
